// File: rtl/approx_log_divider_pipe.sv
// Three-stage Mitchell log-domain approximate signed divider with valid/ready flow control.
// S1 normalises both operands, S2 subtracts the log fields, S3 antilogs, signs and saturates.
module approx_log_divider_pipe #(
    parameter int WIDTH      = 16,
    parameter int KEEP_WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_q,
    output logic             o_dz
);
    localparam int KW = $clog2(WIDTH);
    localparam int EW = KW + 2;
    localparam int MW = WIDTH + KEEP_WIDTH + 1;
    localparam logic [MW-1:0] LIM = MW'(1) << (WIDTH - 1);

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [KW-1:0] lod(input logic [WIDTH-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) k = KW'(i);
        return k;
    endfunction

    // Left-justify so the leading one sits at the MSB; the field is the next KEEP_WIDTH bits.
    function automatic logic [KEEP_WIDTH-1:0] frac(input logic [WIDTH-1:0] v, input logic [KW-1:0] k);
        logic [WIDTH-1:0] n;
        n = v << (KW'(WIDTH - 1) - k);
        return KEEP_WIDTH'(n >> (WIDTH - 1 - KEEP_WIDTH));
    endfunction

    logic [3:1] vld_pipe;
    logic [3:1] en;

    assign en[3]   = ~vld_pipe[3] | i_ready;
    assign en[2]   = ~vld_pipe[2] | en[3];
    assign en[1]   = ~vld_pipe[1] | en[2];
    assign o_ready = en[1];
    assign o_valid = vld_pipe[3];

    // Stage 1 state
    logic                  s1_s, s1_az, s1_bz, s1_an;
    logic [KW-1:0]         s1_ka, s1_kb;
    logic [KEEP_WIDTH-1:0] s1_xa, s1_xb;
    // Stage 2 state
    logic                  s2_s, s2_az, s2_bz, s2_an;
    logic signed [EW-1:0]  s2_k;
    logic [KEEP_WIDTH-1:0] s2_f;

    logic [WIDTH-1:0] ma, mb;
    assign ma = abs_val(i_a);
    assign mb = abs_val(i_b);

    logic [KEEP_WIDTH:0]  d;
    logic signed [EW-1:0] k_nxt;
    assign d     = {1'b0, s1_xa} - {1'b0, s1_xb};
    assign k_nxt = $signed({{(EW-KW){1'b0}}, s1_ka}) - $signed({{(EW-KW){1'b0}}, s1_kb})
                 - $signed({{(EW-1){1'b0}}, d[KEEP_WIDTH]});

    logic [MW-1:0]    mag;
    logic [WIDTH-1:0] q_nxt;
    logic             dz_nxt;

    always_comb begin
        mag = '0;
        if (!s2_k[EW-1])
            mag = (MW'({1'b1, s2_f}) << s2_k[EW-2:0]) >> KEEP_WIDTH;
        dz_nxt = s2_bz;
        if (s2_bz)
            q_nxt = s2_an ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else if (s2_az)
            q_nxt = '0;
        else if (!s2_s && mag > LIM - 1'b1)
            q_nxt = {1'b0, {(WIDTH-1){1'b1}}};
        else if (s2_s && mag > LIM)
            q_nxt = {1'b1, {(WIDTH-1){1'b0}}};
        else
            q_nxt = s2_s ? (~mag[WIDTH-1:0] + 1'b1) : mag[WIDTH-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe <= '0;
            s1_s <= 1'b0; s1_az <= 1'b0; s1_bz <= 1'b0; s1_an <= 1'b0;
            s1_ka <= '0; s1_kb <= '0; s1_xa <= '0; s1_xb <= '0;
            s2_s <= 1'b0; s2_az <= 1'b0; s2_bz <= 1'b0; s2_an <= 1'b0;
            s2_k <= '0; s2_f <= '0;
            o_q  <= '0;
            o_dz <= 1'b0;
        end else begin
            if (en[1]) vld_pipe[1] <= i_valid;
            if (en[2]) vld_pipe[2] <= vld_pipe[1];
            if (en[3]) vld_pipe[3] <= vld_pipe[2];
            if (en[1] && i_valid) begin
                s1_s  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                s1_az <= (i_a == '0);
                s1_bz <= (i_b == '0);
                s1_an <= i_a[WIDTH-1];
                s1_ka <= lod(ma);
                s1_kb <= lod(mb);
                s1_xa <= frac(ma, lod(ma));
                s1_xb <= frac(mb, lod(mb));
            end
            if (en[2] && vld_pipe[1]) begin
                s2_s  <= s1_s;
                s2_az <= s1_az;
                s2_bz <= s1_bz;
                s2_an <= s1_an;
                s2_k  <= k_nxt;
                s2_f  <= d[KEEP_WIDTH-1:0];
            end
            if (en[3] && vld_pipe[2]) begin
                o_q  <= q_nxt;
                o_dz <= dz_nxt;
            end
        end
    end
endmodule

// File: tb/tb_approx_log_divider_pipe.sv
// Directed bench for approx_log_divider_pipe at WIDTH=16, KEEP_WIDTH=5.
module tb_approx_log_divider_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_a = '0;
    logic [15:0] i_b = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [15:0] o_q;
    logic        o_dz;

    int total = 0;
    int bad = 0;

    approx_log_divider_pipe #(.WIDTH(16), .KEEP_WIDTH(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_q(o_q), .o_dz(o_dz)
    );

    always #5 i_clk = ~i_clk;

    task automatic test_reset();
        @(negedge i_clk);
        total++;
        if (o_valid !== 1'b0 || o_q !== 16'd0 || o_dz !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b q=%0d dz=%b want 0/0/0", o_valid, o_q, o_dz);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: o_ready=%b want 1", o_ready);
        end
    endtask

    // Accept counts as edge 1; o_valid must first be seen after edge 3.
    task automatic test_latency();
        i_a = 16'd96; i_b = 16'd3; i_valid = 1'b1; i_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL lat_edge1: o_valid=%b want 0", o_valid); end
        @(negedge i_clk);
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL lat_edge2: o_valid=%b want 0", o_valid); end
        @(negedge i_clk);
        total++;
        if (o_valid !== 1'b1 || o_q !== 16'd32 || o_dz !== 1'b0) begin
            bad++;
            $display("FAIL lat_edge3: valid=%b q=%0d dz=%b want 1/32/0", o_valid, $signed(o_q), o_dz);
        end
        @(negedge i_clk);
    endtask

    task automatic test_arith();
        logic [15:0] va[11] = '{16'd100, -16'sd100, 16'd64, 16'd3, -16'sd5, 16'd0,
                                16'h8000, 16'h8000, 16'd0, 16'd96, 16'd96};
        logic [15:0] vb[11] = '{16'd10, 16'd10, 16'd3, 16'd64, 16'd0, 16'd0,
                                16'hFFFF, 16'd1, 16'd7, 16'd8, -16'sd3};
        logic [15:0] vq[11] = '{16'd10, -16'sd10, 16'd24, 16'd0, 16'h8000, 16'h7FFF,
                                16'h7FFF, 16'h8000, 16'd0, 16'd12, -16'sd32};
        logic        vd[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            int n;
            i_a = va[i]; i_b = vb[i]; i_valid = 1'b1; i_ready = 1'b1;
            @(negedge i_clk);
            i_valid = 1'b0;
            n = 0;
            while (!o_valid && n < 10) begin @(negedge i_clk); n++; end
            total++;
            if (o_valid !== 1'b1 || o_q !== vq[i] || o_dz !== vd[i]) begin
                bad++;
                $display("FAIL arith_%0d: a=%0d b=%0d got valid=%b q=%0d dz=%b want q=%0d dz=%b",
                         i, $signed(va[i]), $signed(vb[i]), o_valid, $signed(o_q), o_dz,
                         $signed(vq[i]), vd[i]);
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcv = 0;
        int cyc = 0;
        logic held_v = 1'b0;
        logic [15:0] held_q = '0;
        logic exp_rdy;
        while (rcv < 8 && cyc < 100) begin
            i_ready = (cyc % 3 == 0);
            i_valid = (sent < 8);
            i_a = 16'(32 * (sent + 1));
            i_b = 16'd1;
            #1;
            if (held_v) begin
                total++;
                if (o_valid !== 1'b1 || o_q !== held_q) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%b q=%0d want 1/%0d", o_valid, o_q, held_q);
                end
            end
            exp_rdy = !((sent - rcv) == 3 && !i_ready);
            total++;
            if (o_ready !== exp_rdy) begin
                bad++;
                $display("FAIL bp_ready cyc=%0d: o_ready=%b want %b", cyc, o_ready, exp_rdy);
            end
            if (o_valid && i_ready) begin
                total++;
                if (o_q !== 16'(32 * (rcv + 1))) begin
                    bad++;
                    $display("FAIL bp_order_%0d: q=%0d want %0d", rcv, o_q, 32 * (rcv + 1));
                end
                rcv++;
            end
            held_v = o_valid && !i_ready;
            held_q = o_q;
            if (i_valid && o_ready) sent++;
            cyc++;
            @(negedge i_clk);
        end
        total++;
        if (rcv != 8) begin bad++; $display("FAIL bp_count: received=%0d want 8", rcv); end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_midreset();
        int seen = 0;
        i_ready = 1'b0; i_valid = 1'b1; i_a = 16'd96; i_b = 16'd3;
        repeat (3) @(negedge i_clk);
        i_valid = 1'b0;
        total++;
        if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_full: valid=%b ready=%b want 1/0", o_valid, o_ready);
        end
        #2 i_rst = 1'b1;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_q !== 16'd0 || o_dz !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: valid=%b q=%0d dz=%b want 0/0/0", o_valid, o_q, o_dz);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_ready = 1'b1;
        repeat (10) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rst_flush: results after reset=%0d want 0", seen); end
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: o_ready=%b want 1", o_ready); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_back_to_back();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
